// File: rtl/mul_div_seq.sv
// Multi-cycle signed MUL (Booth radix-2) / DIV (non-restoring on magnitudes) sequencer.
// Optional MD_DIV0_FLAG_EN adds the dz divide-by-zero flag port.
module mul_div_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [4:0]  MUL_SEL = 5'b01010,
    parameter logic [4:0]  DIV_SEL = 5'b01011
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         select,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
`ifdef MD_DIV0_FLAG_EN
    ,
    output logic               dz
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e           state;
    logic             op_div;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH+1:0] acc_q;
    logic             qm1_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [WIDTH-1:0] a_in_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_next;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] fix_z;

    assign accept = start && (select == MUL_SEL || select == DIV_SEL);

    always_comb begin
        // Negating 0x80000000 wraps to itself, which reads correctly as unsigned 2^31.
        a_in_mag = A[WIDTH-1] ? -A : A;
        b_mag    = b_q[WIDTH-1] ? -{1'b1, b_q} : {1'b0, b_q};
        mcand    = {{2{a_q[WIDTH-1]}}, a_q};

        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand;
            2'b10:   booth_sum = acc_q - mcand;
            default: booth_sum = acc_q;
        endcase

        // Partial remainder fits in WIDTH+1 signed bits before the shift.
        div_shift = {acc_q[WIDTH:0], q_q[WIDTH-1]};
        div_next  = acc_q[WIDTH+1] ? div_shift + {1'b0, b_mag} : div_shift - {1'b0, b_mag};

        rem_mag = acc_q[WIDTH-1:0] + (acc_q[WIDTH+1] ? b_mag[WIDTH-1:0] : '0);
        quo     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -q_q : q_q;
        rem     = a_q[WIDTH-1] ? -rem_mag : rem_mag;

        if (!op_div) begin
            fix_z = {acc_q[WIDTH-1:0], q_q};
        end else if (b_q == '0) begin
            fix_z = {a_q, {WIDTH{1'b1}}};
        end else begin
            fix_z = {rem, quo};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            Z      <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            acc_q  <= '0;
            qm1_q  <= 1'b0;
`ifdef MD_DIV0_FLAG_EN
            dz     <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (accept) begin
                        op_div <= (select == DIV_SEL);
                        a_q    <= A;
                        b_q    <= B;
                        q_q    <= (select == DIV_SEL) ? a_in_mag : B;
                        acc_q  <= '0;
                        qm1_q  <= 1'b0;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= StRun;
`ifdef MD_DIV0_FLAG_EN
                        dz     <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    if (op_div) begin
                        acc_q <= div_next;
                        q_q   <= {q_q[WIDTH-2:0], ~div_next[WIDTH+1]};
                    end else begin
                        acc_q <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
                        q_q   <= {booth_sum[0], q_q[WIDTH-1:1]};
                        qm1_q <= q_q[0];
                    end
                    if (cnt == '0) begin
                        state <= StFix;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StFix: begin
                    Z     <= fix_z;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= StDone;
`ifdef MD_DIV0_FLAG_EN
                    dz    <= op_div && (b_q == '0);
`endif
                end
                default: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed corner cases plus random ops vs. an arithmetic model.
module tb_mul_div_seq;

    localparam logic [4:0] MUL_SEL = 5'b01010;
    localparam logic [4:0] DIV_SEL = 5'b01011;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  select = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [63:0] Z;
`ifdef MD_DIV0_FLAG_EN
    logic        dz;
`endif

    int total = 0;
    int bad = 0;
    logic [63:0] last_z = '0;

    mul_div_seq dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .select (select),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Z      (Z)
`ifdef MD_DIV0_FLAG_EN
        ,
        .dz     (dz)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic; SV division truncates toward zero.
    function automatic logic [63:0] model(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sel == MUL_SEL) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        logic [63:0] exp;
        int n;
        bit held;
        exp = model(sel, a, b);
        @(negedge clock);
        start = 1'b1; select = sel; A = a; B = b;
        @(negedge clock);
        start = 1'b0; A = $urandom; B = $urandom; select = 5'($urandom);
        check({tag, "_busy_accept"}, 64'(busy), 64'd1);
`ifdef MD_DIV0_FLAG_EN
        check({tag, "_dz_cleared"}, 64'(dz), 64'd0);
`endif
        n = 0;
        held = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1 || Z !== last_z) held = 1'b0;
            if (poke && n == 4) begin
                start = 1'b1; select = MUL_SEL; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_z_held"}, 64'(held), 64'd1);
        check({tag, "_z"}, Z, exp);
`ifdef MD_DIV0_FLAG_EN
        check({tag, "_dz"}, 64'(dz), 64'((sel == DIV_SEL) && (b == 32'd0)));
`endif
        last_z = exp;
        if (poke) begin
            start = 1'b1; select = DIV_SEL; A = $urandom; B = $urandom;
        end
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_z", Z, 64'd0);
`ifdef MD_DIV0_FLAG_EN
        check("rst_dz", 64'(dz), 64'd0);
`endif
        clear = 1'b0;

        do_op("mul_7_m3", MUL_SEL, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_op("mul_min_min", MUL_SEL, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("mul_m1_1", MUL_SEL, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("div_m7_2", DIV_SEL, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("div_100_7", DIV_SEL, 32'd100, 32'd7, 1'b0);
        do_op("div_min_m1", DIV_SEL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div_5_0", DIV_SEL, 32'd5, 32'd0, 1'b0);
        do_op("mul_after_dz", MUL_SEL, 32'd3, 32'd4, 1'b0);
        do_op("mul_poke", MUL_SEL, 32'd12345, 32'hFFFF_FD5A, 1'b1);

        // Start with an unsupported select must do nothing.
        @(negedge clock);
        start = 1'b1; select = 5'b00000; A = 32'd9; B = 32'd9;
        @(negedge clock);
        start = 1'b0;
        check("bad_sel_busy", 64'(busy), 64'd0);
        begin
            bit seen;
            seen = 1'b0;
            repeat (36) begin
                @(negedge clock);
                if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            end
            check("bad_sel_no_activity", 64'(seen), 64'd0);
            check("bad_sel_z", Z, last_z);
        end

        // clear at edge k+10 of a MUL discards it.
        @(negedge clock);
        start = 1'b1; select = MUL_SEL; A = 32'd55; B = 32'd66;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_z", Z, 64'd0);
        last_z = '0;
        do_op("div_9_3", DIV_SEL, 32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] sel;
            logic [31:0] a, b;
            sel = ($urandom_range(0, 1) == 0) ? MUL_SEL : DIV_SEL;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 32'd1 : -32'd1);
                2: a = 32'h8000_0000;
                3: b = 32'h8000_0000;
                default: ;
            endcase
            do_op("rand", sel, a, b, (i % 8) == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
